l0_instr_fetch_buffer: RTL and testbench

//  Small fully-associative L0 instruction line buffer between the fetch stage and the L1 instruction cache.

---
 rtl/l0_instr_fetch_buffer.sv | 174 +++++++++++++++++
 tb/tb_l0_instr_fetch_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l0_instr_fetch_buffer.sv
// L0 instruction line buffer: fully-associative, round-robin fill, serves 32-bit words to fetch.
// Latency: hit -> instr_valid_out 1 cycle after pc accept; miss -> 1 cycle after L1 line response.
// Backpressure: pc_ready_out only in IDLE; response held until instr_ready_in; one blocking miss.
//
// Ports: clk_in/rst_N_in (async active-low), flush_in; fetch side pc_valid_in/pc_in/pc_ready_out
// and instr_valid_out/instr_out/instr_pc_out/instr_ready_in; L1i side l1_valid_out/l1_ready_in/
// l1_addr_out (request) and l1_valid_in/l1_ready_out/l1_addr_in/l1_value_in (line response).
// Optional macro L0I_PERF_CNT_EN adds hit_count_out/miss_count_out lookup counters.
module l0_instr_fetch_buffer #(
    parameter int ENTRIES    = 4,
    parameter int B          = 64,
    parameter int PADDR_BITS = 64,
    parameter int INSTR_BITS = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  flush_in,
    input  logic                  pc_valid_in,
    input  logic [63:0]           pc_in,
    output logic                  pc_ready_out,
    output logic                  instr_valid_out,
    output logic [INSTR_BITS-1:0] instr_out,
    output logic [63:0]           instr_pc_out,
    input  logic                  instr_ready_in,
    output logic                  l1_valid_out,
    input  logic                  l1_ready_in,
    output logic [63:0]           l1_addr_out,
    input  logic                  l1_valid_in,
    output logic                  l1_ready_out,
    input  logic [PADDR_BITS-1:0] l1_addr_in,
    input  logic [8*B-1:0]        l1_value_in
`ifdef L0I_PERF_CNT_EN
    ,
    output logic [31:0]           hit_count_out,
    output logic [31:0]           miss_count_out
`endif
);
    localparam int OFF    = $clog2(B);
    localparam int TAGW   = PADDR_BITS - OFF;
    localparam int NWORDS = 8 * B / INSTR_BITS;
    localparam int WIDX   = $clog2(NWORDS);
    localparam int EIDX   = $clog2(ENTRIES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]            state_q;
    logic [63:0]           pc_q;
    logic [INSTR_BITS-1:0] instr_q;
    logic [ENTRIES-1:0]    valid_q;
    logic [EIDX-1:0]       rr_q;
    logic                  drop_q;
    logic [TAGW-1:0]       tag_q  [ENTRIES];
    logic [8*B-1:0]        data_q [ENTRIES];

    logic                         hit_any;
    logic                         lookup_hit;
    logic [EIDX-1:0]              hit_idx;
    logic [NWORDS-1:0][INSTR_BITS-1:0] hit_line_w;
    logic [NWORDS-1:0][INSTR_BITS-1:0] resp_line_w;
    logic                         resp_match;
    logic                         resp_take;
    logic                         install;

    // Address bits below word granularity / line offset of the response carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc_in[1:0], l1_addr_in[OFF-1:0]};

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == pc_in[PADDR_BITS-1:OFF]) begin
                hit_any = 1'b1;
                hit_idx = EIDX'(i);
            end
        end
    end

    // A same-cycle flush wins over the lookup, forcing a miss.
    assign lookup_hit  = hit_any && !flush_in;
    assign hit_line_w  = data_q[hit_idx];
    assign resp_line_w = l1_value_in;
    assign resp_match  = l1_addr_in[PADDR_BITS-1:OFF] == pc_q[PADDR_BITS-1:OFF];
    assign resp_take   = (state_q == WAIT) && l1_valid_in && resp_match;
    // Fills requested before (or during) a flush are returned but never installed.
    assign install     = resp_take && !drop_q && !flush_in;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= '0;
            rr_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_valid_in) begin
                        pc_q <= pc_in;
                        if (lookup_hit) begin
                            instr_q <= hit_line_w[pc_in[2 +: WIDX]];
                            state_q <= RESP;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush_in)    drop_q  <= 1'b1;
                    if (l1_ready_in) state_q <= WAIT;
                end
                WAIT: begin
                    if (flush_in) drop_q <= 1'b1;
                    if (resp_take) begin
                        instr_q <= resp_line_w[pc_q[2 +: WIDX]];
                        state_q <= RESP;
                    end
                    if (install) begin
                        valid_q[rr_q] <= 1'b1;
                        rr_q          <= rr_q + EIDX'(1);
                    end
                end
                default: begin
                    if (instr_ready_in) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                    end
                end
            endcase
            if (flush_in) valid_q <= '0;
        end
    end

    // Line storage needs no reset: every entry is guarded by its valid bit.
    always_ff @(posedge clk_in) begin
        if (install) begin
            tag_q[rr_q]  <= pc_q[PADDR_BITS-1:OFF];
            data_q[rr_q] <= l1_value_in;
        end
    end

`ifdef L0I_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && pc_valid_in) begin
            if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else            miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;
`else
    // Lookup counters are not built in this configuration.
`endif

    assign pc_ready_out    = state_q == IDLE;
    assign l1_valid_out    = state_q == REQ;
    assign l1_ready_out    = state_q == WAIT;
    assign instr_valid_out = state_q == RESP;
    assign instr_out       = instr_q;
    assign instr_pc_out    = pc_q;
    assign l1_addr_out     = {pc_q[63:OFF], {OFF{1'b0}}};

endmodule

// File: tb/tb_l0_instr_fetch_buffer.sv
module tb_l0_instr_fetch_buffer;
    logic         clk_in = 1'b0;
    logic         rst_N_in = 1'b0;
    logic         flush_in = 1'b0;
    logic         pc_valid_in = 1'b0;
    logic [63:0]  pc_in = '0;
    logic         pc_ready_out;
    logic         instr_valid_out;
    logic [31:0]  instr_out;
    logic [63:0]  instr_pc_out;
    logic         instr_ready_in = 1'b0;
    logic         l1_valid_out;
    logic         l1_ready_in = 1'b0;
    logic [63:0]  l1_addr_out;
    logic         l1_valid_in = 1'b0;
    logic         l1_ready_out;
    logic [63:0]  l1_addr_in = '0;
    logic [511:0] l1_value_in = '0;

    int checks = 0;
    int failures = 0;

    l0_instr_fetch_buffer dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in), .flush_in(flush_in),
        .pc_valid_in(pc_valid_in), .pc_in(pc_in), .pc_ready_out(pc_ready_out),
        .instr_valid_out(instr_valid_out), .instr_out(instr_out), .instr_pc_out(instr_pc_out),
        .instr_ready_in(instr_ready_in), .l1_valid_out(l1_valid_out), .l1_ready_in(l1_ready_in),
        .l1_addr_out(l1_addr_out), .l1_valid_in(l1_valid_in), .l1_ready_out(l1_ready_out),
        .l1_addr_in(l1_addr_in), .l1_value_in(l1_value_in)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] pc;
        int          lat;         // cycles L1 holds l1_ready_in low
        bit          stale;       // L1 returns a different line first
        bit          flush_idle;  // flush coincident with the pc request
        bit          flush_wait;  // flush pulse while waiting for the line
        int          hold;        // cycles fetch withholds instr_ready_in
        bit          exp_miss;
        logic [31:0] exp_instr;
    } vec_t;

    // Reference: L1 memory contents and the set of resident lines, oldest first.
    logic [63:0] resident[$];

    function automatic logic [31:0] mem_word(input logic [63:0] line, input int w);
        if (line == 64'h1000 && w == 1) return 32'hDEADBEEF;
        return (line[31:0] + 32'(w) * 32'h0001_0001) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [511:0] line_data(input logic [63:0] line);
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = mem_word(line, w);
        return d;
    endfunction

    function automatic logic [31:0] expw(input logic [63:0] pc);
        return mem_word(pc & ~64'h3F, int'(pc[5:2]));
    endfunction

    function automatic bit model_resident(input logic [63:0] line);
        foreach (resident[i]) if (resident[i] == line) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one fetch from IDLE to completion, acting as fetch stage and L1i.
    task automatic run_vec(input vec_t v);
        logic [63:0] line;
        bit          saw_req;
        int          n;
        line = v.pc & ~64'h3F;
        check("pc_ready_idle", pc_ready_out, 1);
        pc_valid_in = 1'b1;
        pc_in       = v.pc;
        flush_in    = v.flush_idle;
        tick();
        pc_valid_in = 1'b0;
        flush_in    = 1'b0;
        pc_in       = {$urandom, $urandom};
        saw_req     = l1_valid_out;
        check("miss_path", saw_req, v.exp_miss);
        if (saw_req) begin
            check("l1_addr", l1_addr_out, line);
            check("req_not_rdy", l1_ready_out, 0);
            for (int i = 0; i < v.lat; i++) begin
                tick();
                check("req_held", l1_valid_out, 1);
            end
            l1_ready_in = 1'b1;
            tick();
            l1_ready_in = 1'b0;
            check("req_dropped", l1_valid_out, 0);
            check("wait_rdy", l1_ready_out, 1);
            if (v.flush_wait) begin
                flush_in = 1'b1;
                tick();
                flush_in = 1'b0;
            end
            if (v.stale) begin
                l1_valid_in = 1'b1;
                l1_addr_in  = line ^ 64'h1000;
                l1_value_in = line_data(line ^ 64'h1000);
                tick();
                l1_valid_in = 1'b0;
                check("stale_ignored", l1_ready_out, 1);
                check("stale_no_resp", instr_valid_out, 0);
            end
            l1_valid_in = 1'b1;
            l1_addr_in  = line;
            l1_value_in = line_data(line);
            tick();
            l1_valid_in = 1'b0;
        end
        n = 0;
        while (!instr_valid_out && n < 20) begin
            tick();
            n++;
        end
        check("resp_latency", 64'(n), 0);
        check("instr", instr_out, v.exp_instr);
        check("instr_pc", instr_pc_out, v.pc);
        check("busy_no_pc_ready", pc_ready_out, 0);
        for (int i = 0; i < v.hold; i++) begin
            tick();
            check("bp_valid", instr_valid_out, 1);
            check("bp_instr", instr_out, v.exp_instr);
            check("bp_pc", instr_pc_out, v.pc);
            check("bp_pc_ready", pc_ready_out, 0);
        end
        instr_ready_in = 1'b1;
        tick();
        instr_ready_in = 1'b0;
        check("resp_done", instr_valid_out, 0);
        check("back_idle", pc_ready_out, 1);
        // Reference update: flush empties the set; an undisturbed miss adds the
        // line, evicting the oldest when all ENTRIES are occupied.
        if (v.flush_idle) resident.delete();
        if (v.exp_miss) begin
            if (v.flush_wait) begin
                resident.delete();
            end else begin
                if (resident.size() == 4) void'(resident.pop_front());
                resident.push_back(line);
            end
        end
    endtask

    vec_t tbl[15];
    vec_t rv;

    initial begin
        //             pc          lat stale fi fw hold miss instr
        tbl[0]  = '{64'h1004, 2, 0, 0, 0, 0, 1, 32'hDEADBEEF};
        tbl[1]  = '{64'h103C, 0, 0, 0, 0, 0, 0, expw(64'h103C)};
        tbl[2]  = '{64'h0000, 1, 0, 1, 0, 0, 1, expw(64'h0000)};
        tbl[3]  = '{64'h0040, 0, 0, 0, 0, 0, 1, expw(64'h0040)};
        tbl[4]  = '{64'h0080, 3, 0, 0, 0, 0, 1, expw(64'h0080)};
        tbl[5]  = '{64'h00C0, 0, 0, 0, 0, 0, 1, expw(64'h00C0)};
        tbl[6]  = '{64'h0100, 1, 0, 0, 0, 0, 1, expw(64'h0100)};
        tbl[7]  = '{64'h0044, 0, 0, 0, 0, 0, 0, expw(64'h0044)};
        tbl[8]  = '{64'h0000, 0, 0, 0, 0, 0, 1, expw(64'h0000)};
        tbl[9]  = '{64'h2000, 1, 1, 0, 0, 0, 1, expw(64'h2000)};
        tbl[10] = '{64'h2008, 0, 0, 0, 0, 0, 0, expw(64'h2008)};
        tbl[11] = '{64'h2008, 0, 0, 1, 0, 0, 1, expw(64'h2008)};
        tbl[12] = '{64'h4000, 0, 0, 0, 1, 0, 1, expw(64'h4000)};
        tbl[13] = '{64'h4000, 1, 0, 0, 0, 0, 1, expw(64'h4000)};
        tbl[14] = '{64'h4010, 0, 0, 0, 0, 5, 0, expw(64'h4010)};

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_pc_ready", pc_ready_out, 1);
        check("rst_instr_valid", instr_valid_out, 0);
        check("rst_instr", instr_out, 0);
        check("rst_instr_pc", instr_pc_out, 0);
        check("rst_l1_valid", l1_valid_out, 0);
        check("rst_l1_addr", l1_addr_out, 0);
        check("rst_l1_ready", l1_ready_out, 0);
        rst_N_in = 1'b1;
        tick();

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset asserted while a request is outstanding
        pc_valid_in = 1'b1;
        pc_in       = 64'h9000;
        tick();
        pc_valid_in = 1'b0;
        check("req_before_rst", l1_valid_out, 1);
        rst_N_in = 1'b0;
        #1;
        check("rst_req_l1_valid", l1_valid_out, 0);
        check("rst_req_pc_ready", pc_ready_out, 1);
        check("rst_req_l1_ready", l1_ready_out, 0);
        check("rst_req_instr_valid", instr_valid_out, 0);
        tick();
        rst_N_in = 1'b1;
        resident.delete();
        tick();

        // Randomized traffic over a small line pool to exercise hits, evictions and flushes
        for (int k = 0; k < 60; k++) begin
            rv.pc         = (64'($urandom_range(0, 6)) << 6) | (64'($urandom_range(0, 15)) << 2)
                            | 64'($urandom_range(0, 3));
            rv.lat        = $urandom_range(0, 3);
            rv.flush_idle = ($urandom_range(0, 7) == 0);
            rv.hold       = $urandom_range(0, 2);
            rv.exp_miss   = rv.flush_idle || !model_resident(rv.pc & ~64'h3F);
            rv.stale      = rv.exp_miss && ($urandom_range(0, 4) == 0);
            rv.flush_wait = rv.exp_miss && ($urandom_range(0, 7) == 0);
            rv.exp_instr  = expw(rv.pc);
            run_vec(rv);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
